// File: rtl/defs_pkg.sv
// rtl/defs_pkg.sv - shared types and helpers for the instruction fetch aligner
//
// Purpose: aligner state enum, the RVC low-bit mask, and small helpers for
// picking a halfword out of a 64-bit fetch line and classifying it.
// Ports: none (package).
package defs_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      CROSS = 1'b1
   } ifu_align_state_t;

   // Low two bits of a 32-bit instruction's first halfword are both set.
   localparam logic [1:0] RvcMask = 2'b11;

   function automatic logic [15:0] get_hw(input logic [63:0] line, input logic [1:0] k);
      return line[{k, 4'b0000} +: 16];
   endfunction

   function automatic logic is_rvc(input logic [15:0] hw);
      return (hw[1:0] & RvcMask) != RvcMask;
   endfunction

endpackage

// File: rtl/ifu_aligner.sv
// rtl/ifu_aligner.sv - aligns 16/32-bit RISC-V instructions out of 64-bit fetch lines
//
// Purpose: walks the FIFO head line halfword by halfword starting at pc_q,
// emitting one compressed or full instruction per step into a registered
// output slot; a 32-bit instruction whose first half is the last halfword of
// a line is carried over (CROSS) and completed with halfword 0 of the next.
// Ports:
//   clk, rst                  clock, async active-high reset
//   wordline, empty           FIFO head line (first-word-fall-through) and empty flag
//   row_flush                 pops the FIFO head this cycle (combinational)
//   redirect, redirect_pc     redirect pulse and new PC[31:1]
//   instr_ready               decoder accepts the output slot
//   instr_valid, instr,       registered output slot: instruction, PC[31:1],
//   instr_pc, instr_compressed  and RVC flag
module ifu_aligner
   import defs_pkg::*;
#(
   parameter logic [31:0] ResetPc = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] wordline,
   input  logic        empty,
   output logic        row_flush,
   input  logic        redirect,
   input  logic [30:0] redirect_pc,
   input  logic        instr_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [30:0] instr_pc,
   output logic        instr_compressed
);

   localparam logic [30:0] ResetPcHw = ResetPc[31:1];

   ifu_align_state_t state_q, state_d;
   logic [30:0] pc_q, pc_d;
   logic [15:0] carry_q, carry_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [30:0] ipc_q, ipc_d;
   logic        icomp_q, icomp_d;
   logic        flush_d;

   logic [1:0]  off;
   logic [15:0] hw_cur;
   logic [15:0] hw_nxt;
   logic [15:0] hw_first;
   logic        slot_free;
   logic        step;

   assign off       = pc_q[1:0];
   assign hw_cur    = get_hw(wordline, off);
   // Only consulted when off < 3, so the 2-bit wrap of off+1 never matters.
   assign hw_nxt    = get_hw(wordline, off + 2'd1);
   assign hw_first  = wordline[15:0];
   assign slot_free = !valid_q || instr_ready;
   assign step      = !empty && slot_free && !redirect;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      carry_d = carry_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      icomp_d = icomp_q;
      flush_d = 1'b0;

      if (redirect) begin
         valid_d = 1'b0;
         pc_d    = redirect_pc;
         carry_d = 16'h0;
         state_d = RUN;
      end else begin
         // A held instruction accepted this cycle leaves the slot unless
         // a new one replaces it below.
         if (instr_ready) begin
            valid_d = 1'b0;
         end
         if (step) begin
            case (state_q)
               RUN: begin
                  if (is_rvc(hw_cur)) begin
                     valid_d = 1'b1;
                     instr_d = {16'h0, hw_cur};
                     ipc_d   = pc_q;
                     icomp_d = 1'b1;
                     pc_d    = pc_q + 31'd1;
                     flush_d = (off == 2'd3);
                  end else if (off != 2'd3) begin
                     valid_d = 1'b1;
                     instr_d = {hw_nxt, hw_cur};
                     ipc_d   = pc_q;
                     icomp_d = 1'b0;
                     pc_d    = pc_q + 31'd2;
                     flush_d = (off == 2'd2);
                  end else begin
                     // Upper half lives in the next line: park the low half.
                     carry_d = hw_cur;
                     flush_d = 1'b1;
                     state_d = CROSS;
                  end
               end
               CROSS: begin
                  valid_d = 1'b1;
                  instr_d = {hw_first, carry_q};
                  ipc_d   = pc_q;
                  icomp_d = 1'b0;
                  pc_d    = pc_q + 31'd2;
                  state_d = RUN;
               end
               default: state_d = RUN;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= ResetPcHw;
         carry_q <= 16'h0;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         ipc_q   <= 31'h0;
         icomp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         icomp_q <= icomp_d;
      end
   end

   // Combinational pop; masked while reset is held so no line is lost.
   assign row_flush        = flush_d && !rst;
   assign instr_valid      = valid_q;
   assign instr            = instr_q;
   assign instr_pc         = ipc_q;
   assign instr_compressed = icomp_q;

endmodule

// File: tb/tb_ifu_aligner.sv
// tb/tb_ifu_aligner.sv - scoreboard bench for ifu_aligner
module tb_ifu_aligner;

   logic        clk;
   logic        rst;
   logic [63:0] wordline;
   logic        empty;
   logic        row_flush;
   logic        redirect;
   logic [30:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [30:0] instr_pc;
   logic        instr_compressed;

   typedef struct {
      logic [31:0] i;
      logic [30:0] pc;
      logic        c;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] fifo_q[$];
   int          checks;
   int          failures;
   logic        rf_s;

   ifu_aligner #(.ResetPc(32'h8000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .wordline         (wordline),
      .empty            (empty),
      .row_flush        (row_flush),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .instr_ready      (instr_ready),
      .instr_valid      (instr_valid),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_compressed (instr_compressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic refresh();
      empty    = (fifo_q.size() == 0);
      wordline = (fifo_q.size() == 0) ? 64'h0 : fifo_q[0];
   endtask

   task automatic push_line(input logic [63:0] l);
      fifo_q.push_back(l);
      refresh();
   endtask

   task automatic expect_instr(input logic [31:0] i, input logic [30:0] pc, input logic c);
      exp_t e;
      e.i  = i;
      e.pc = pc;
      e.c  = c;
      sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drain(input string name);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 100) begin
         @(posedge clk);
         i++;
      end
      #2;
      chk({name, "_drain"}, 64'(sb.size()), 64'd0);
      cyc(2);
      chk({name, "_fifo_consumed"}, 64'(fifo_q.size()), 64'd0);
   endtask

   // FIFO model: pops the head on the edge after row_flush was seen.
   initial begin
      rf_s = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         rf_s = row_flush;
         if (rf_s) chk("flush_while_empty", 64'(empty), 64'd0);
         @(posedge clk);
         #1;
         if (rf_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
         refresh();
      end
   end

   // Monitor: compares every accepted instruction against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_instr", 64'(instr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("mon_instr", 64'(instr), 64'(e.i));
               chk("mon_pc", 64'(instr_pc), 64'(e.pc));
               chk("mon_compressed", 64'(instr_compressed), 64'(e.c));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 31'h0;
      instr_ready = 1'b1;
      empty       = 1'b1;
      wordline    = 64'h0;
      cyc(2);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_pc", 64'(instr_pc), 64'd0);
      chk("rst_comp", 64'(instr_compressed), 64'd0);
      chk("rst_flush", 64'(row_flush), 64'd0);
      rst = 1'b0;
      cyc(1);

      // Four RVC halfwords, back-to-back, popped on the fourth.
      expect_instr(32'h0000_0008, 31'h4000_0000, 1'b1);
      expect_instr(32'h0000_0004, 31'h4000_0001, 1'b1);
      expect_instr(32'h0000_0002, 31'h4000_0002, 1'b1);
      expect_instr(32'h0000_0001, 31'h4000_0003, 1'b1);
      push_line(64'h0001_0002_0004_0008);
      cyc(1);
      chk("latency_valid", 64'(instr_valid), 64'd1);
      cyc(3);
      chk("back_to_back", 64'(sb.size()), 64'd1);
      drain("four_rvc");

      // 32-bit at off 0, RVC at off 2, straddle from hw3 into next line.
      expect_instr(32'h0000_0013, 31'h4000_0004, 1'b0);
      expect_instr(32'h0000_0001, 31'h4000_0006, 1'b1);
      expect_instr(32'h0010_0093, 31'h4000_0007, 1'b0);
      expect_instr(32'h0000_4501, 31'h4000_0009, 1'b1);
      expect_instr(32'h1234_0537, 31'h4000_000A, 1'b0);
      push_line(64'h0093_0001_0000_0013);
      push_line(64'h1234_0537_4501_0010);
      drain("straddle");

      // Back-pressure: payload held, no pop, pc frozen.
      instr_ready = 1'b0;
      expect_instr(32'h0000_0013, 31'h4000_000C, 1'b0);
      expect_instr(32'h0000_0001, 31'h4000_000E, 1'b1);
      expect_instr(32'h0000_0000, 31'h4000_000F, 1'b1);
      push_line(64'h0000_0001_0000_0013);
      cyc(1);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 64'(instr_valid), 64'd1);
         chk("stall_instr", 64'(instr), 64'h0000_0013);
         chk("stall_flush", 64'(row_flush), 64'd0);
         cyc(1);
      end
      instr_ready = 1'b1;
      drain("stall");

      // Reach CROSS, then redirect: carry must be dropped.
      expect_instr(32'h0000_0005, 31'h4000_0010, 1'b1);
      expect_instr(32'h0000_0009, 31'h4000_0011, 1'b1);
      expect_instr(32'h0000_000D, 31'h4000_0012, 1'b1);
      push_line(64'h0073_000D_0009_0005);
      drain("to_cross");
      redirect    = 1'b1;
      redirect_pc = 31'h4000_0083;
      cyc(1);
      redirect = 1'b0;
      chk("redirect_valid", 64'(instr_valid), 64'd0);
      expect_instr(32'h0000_0041, 31'h4000_0083, 1'b1);
      push_line(64'h0041_FFFF_FFFF_FFFF);
      drain("redirect");

      // Reset while in CROSS: outputs clear at once, carry discarded.
      expect_instr(32'h0000_001D, 31'h4000_0084, 1'b1);
      expect_instr(32'h0000_0019, 31'h4000_0085, 1'b1);
      expect_instr(32'h0000_0015, 31'h4000_0086, 1'b1);
      push_line(64'h00B3_0015_0019_001D);
      drain("to_cross2");
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(instr_valid), 64'd0);
      chk("midrst_instr", 64'(instr), 64'd0);
      chk("midrst_pc", 64'(instr_pc), 64'd0);
      chk("midrst_comp", 64'(instr_compressed), 64'd0);
      chk("midrst_flush", 64'(row_flush), 64'd0);
      cyc(2);
      rst = 1'b0;
      expect_instr(32'h0000_0513, 31'h4000_0000, 1'b0);
      expect_instr(32'h0000_0001, 31'h4000_0002, 1'b1);
      expect_instr(32'h0000_0000, 31'h4000_0003, 1'b1);
      push_line(64'h0000_0001_0000_0513);
      drain("after_reset");

      // Straddle across the top of the address space: pc wraps to 1.
      redirect    = 1'b1;
      redirect_pc = 31'h7FFF_FFFF;
      cyc(1);
      redirect = 1'b0;
      expect_instr(32'h0000_00EF, 31'h7FFF_FFFF, 1'b0);
      expect_instr(32'h0000_0011, 31'h0000_0001, 1'b1);
      expect_instr(32'h0000_0021, 31'h0000_0002, 1'b1);
      expect_instr(32'h0000_0031, 31'h0000_0003, 1'b1);
      push_line(64'h00EF_FFFF_FFFF_FFFF);
      push_line(64'h0031_0021_0011_0000);
      drain("wrap");

      cyc(3);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
